// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port SRAM arbiter (ifetch / load-store); MEM_ARB_RR_EN selects round-robin conflict resolution
module mem_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  // requester 0: instruction fetch
  input  logic        req0_i,
  input  logic        wen_req0_i,
  input  logic [7:0]  addr0_i,
  input  logic [31:0] wdata0_i,
  input  logic [3:0]  wstrb0_i,
  output logic        gnt0_o,
  output logic        rvalid0_o,
  output logic [31:0] rdata0_o,
  // requester 1: load/store
  input  logic        req1_i,
  input  logic        wen_req1_i,
  input  logic [7:0]  addr1_i,
  input  logic [31:0] wdata1_i,
  input  logic [3:0]  wstrb1_i,
  output logic        gnt1_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata1_o,
  // SRAM side
  output logic        mem_cen_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_bwen_o,
  output logic [7:0]  mem_a_o,
  output logic [31:0] mem_d_o,
  input  logic [31:0] mem_q_i,
  // most recently granted port, for observation
  output logic        last_gnt_o
);

  logic       last_gnt_q, last_gnt_d;
  logic [1:0] rd_pend_q, rd_pend_d;
  logic       gnt0, gnt1;
  logic       any_gnt;
  logic       sel_wen;
  logic [3:0] sel_wstrb;

  // Arbitration: a sole requester wins outright; conflicts use the configured policy
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (req0_i && req1_i) begin
`ifdef MEM_ARB_RR_EN
        // the port that did not win last time goes next
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
`else
        // load/store always beats instruction fetch
        gnt1 = 1'b1;
`endif
      end else begin
        gnt0 = req0_i;
        gnt1 = req1_i;
      end
    end
  end

  // SRAM-side mux: route the granted port; idle bus is fully deasserted
  always_comb begin
    any_gnt    = gnt0 | gnt1;
    sel_wen    = gnt1 ? wen_req1_i : wen_req0_i;
    sel_wstrb  = gnt1 ? wstrb1_i   : wstrb0_i;
    mem_a_o    = gnt1 ? addr1_i    : addr0_i;
    mem_d_o    = gnt1 ? wdata1_i   : wdata0_i;
    mem_cen_o  = ~any_gnt;
    mem_wen_o  = ~(any_gnt & sel_wen);
    mem_bwen_o = '1;
    // a write with no strobes still enables the macro but masks every bit
    if (any_gnt && sel_wen) begin
      for (int k = 0; k < 4; k++) begin
        mem_bwen_o[8*k +: 8] = {8{~sel_wstrb[k]}};
      end
    end
  end

  // Next state: remember who won, and flag reads so rvalid lines up with mem_q
  always_comb begin
    last_gnt_d   = last_gnt_q;
    if (gnt0 || gnt1) begin
      last_gnt_d = gnt1;
    end
    rd_pend_d[0] = gnt0 & ~wen_req0_i;
    rd_pend_d[1] = gnt1 & ~wen_req1_i;
  end

  // State registers; reset kills any read in flight and biases the first conflict to port 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 2'b00;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign gnt0_o     = gnt0;
  assign gnt1_o     = gnt1;
  assign rvalid0_o  = rd_pend_q[0];
  assign rvalid1_o  = rd_pend_q[1];
  assign rdata0_o   = mem_q_i;
  assign rdata1_o   = mem_q_i;
  assign last_gnt_o = last_gnt_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports, per requester n in {0 = instruction fetch, 1 = load/store}: reqn in 1 request; wen_reqn in 1 write when high; addrn in 8 word address; wdatan in 32 write data; wstrbn in 4 byte enables, active high.
REQ-004 SHALL have ports, per requester n: gntn out 1 request accepted this cycle (combinational); rvalidn out 1 read data valid (registered); rdatan out 32 read data.
REQ-005 SHALL have SRAM-side ports: mem_cen out 1 chip enable, active low; mem_wen out 1 write enable, active low; mem_bwen out 32 bit write mask, active low; mem_a out 8; mem_d out 32; mem_q in 32 read data, valid one cycle after the read edge.

Function
REQ-006 SHALL grant at most one requester per cycle; gnt0 and gnt1 are never high together.
REQ-007 SHALL grant a sole requesting port in the same cycle; a port without req is never granted.
REQ-008 SHALL, on conflict (req0 and req1 both high), pick the winner per REQ-020/REQ-021.
REQ-009 SHALL drive mem_cen=0 only in a cycle with a grant; otherwise mem_cen=1, mem_wen=1, mem_bwen=all ones.
REQ-010 SHALL mux the granted port's addr/wdata onto mem_a/mem_d; mem_wen = ~wen_req of the granted port.
REQ-011 SHALL expand byte strobes: mem_bwen[8k+7:8k] = {8{~wstrb[k]}} on writes; all ones on reads.
REQ-012 SHALL treat a write with wstrb=0 as a granted no-op: mem_cen=0, mem_bwen all ones, no memory change.
REQ-013 SHALL assert rvalidn for exactly one cycle, cycle T+1, after a read granted to port n in cycle T; never for writes.
REQ-014 SHALL drive rdatan = mem_q to both ports; the value is meaningful only while rvalidn=1.
REQ-015 SHALL sustain one access per cycle: back-to-back reads from either port are granted on consecutive cycles with no bubble.
REQ-016 SHALL require a requester to hold req, wen_req, addr, wdata and wstrb stable until gnt; a request dropped before gnt is discarded without memory access.
REQ-017 SHALL hold last_gnt, a 1-bit register recording the port granted most recently; it updates only in cycles with a grant.
REQ-018 SHALL hold rd_pend[1:0], registered per-port read-issued flags; they drive rvalid0/rvalid1 directly.

Reset
REQ-019 SHALL, while rst=1, force gnt0=gnt1=0, mem_cen=1, mem_wen=1 and mem_bwen all ones; asynchronously clear rvalid0, rvalid1 and rd_pend to 0; set last_gnt=1. A read in flight when reset asserts SHALL produce no rvalid afterwards.

Configuration
REQ-020 SHALL, with macro MEM_ARB_RR_EN defined, resolve conflicts round-robin: the port not equal to last_gnt wins. The first conflict after reset goes to port 0.
REQ-021 SHALL, with MEM_ARB_RR_EN undefined, resolve conflicts by fixed priority: port 1 always wins. last_gnt is still maintained but does not affect arbitration.

Verification
REQ-022 SHALL cover single write then read: port1 writes addr 0x10, data 0xDEADBEEF, wstrb 0xF. Port0 then reads 0x10 -> gnt0 same cycle, rvalid0=1 next cycle with rdata0=0xDEADBEEF, rvalid1=0.
REQ-023 SHALL cover byte write: memory at 0x20 holds 0x11223344; port1 writes 0xAABBCCDD with wstrb 0x2 -> mem_bwen=0xFFFF00FF, and a subsequent read returns 0x1122CC44.
REQ-024 SHALL cover sustained conflict: both ports read continuously for 6 cycles. RR build -> grants alternate 0,1,0,1,0,1. Fixed build -> gnt1 every cycle, gnt0 never.
REQ-025 SHALL cover reset mid-read: a read is granted in cycle T and rst asserts before the edge ending T+1 -> rvalid drops immediately, no rvalid after release, and the first conflict after release goes to port 0 (RR build).
REQ-026 SHALL cover an idle/no-op write: no req for 3 cycles -> mem_cen=1 throughout. Then a write with wstrb=0 -> mem_cen=0, mem_bwen=0xFFFFFFFF, memory unchanged on read-back.
